// File: rtl/memwb_stage_reg_pkg.sv
// Shared MEM/WB payload definitions.
// Default widths match the classic 32-bit MIPS datapath.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;

  typedef struct packed {
    logic                  valid;
    logic                  wb;
    logic                  wmem;
    logic                  load;
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] wdmem;
    logic [RD_W_DEF-1:0]   rd;
  } memwb_t;

  localparam memwb_t BUBBLE = '0;

endpackage

// File: rtl/memwb_stage_reg_fwd_match.sv
// Priority search over the stage array for one forwarding query.
// Lowest index is youngest and wins.
module fwd_match #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int N      = 1
) (
  input  logic [N-1:0]        i_sel,
  input  logic [N*RD_W-1:0]   i_rd,
  input  logic [N*DATA_W-1:0] i_data,
  input  logic [RD_W-1:0]     i_src,
  output logic                o_hit,
  output logic [DATA_W-1:0]   o_data
);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    // scan oldest to youngest so the youngest match is left standing
    for (int i = N - 1; i >= 0; i--) begin
      if (i_sel[i] && i_rd[i*RD_W +: RD_W] == i_src
          && i_src != '0) begin
        o_hit  = 1'b1;
        o_data = i_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/memwb_stage_reg.sv
// Parametrised MEM/WB pipeline register with miss bubbles,
// forwarding lookup and a saturating bubble counter.
module memwb_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              WB_in,
  input  logic              WMEM_in,
  input  logic              load_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] wdMem_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              mem_ready,
  output logic              WB_out,
  output logic              WMEM_out,
  output logic              load_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] wdMem_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              out_valid,
  output logic              stall_req,
  input  logic [RD_W-1:0]   src_rs,
  input  logic [RD_W-1:0]   src_rt,
  output logic              fwd_rs_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rt_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("memwb_stage_reg: STAGES must be 1..3");
  end

  typedef struct packed {
    logic              valid;
    logic              wb;
    logic              wmem;
    logic              load;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] wdmem;
    logic [RD_W-1:0]   rd;
  } stage_t;

  stage_t           r_stg [STAGES];
  logic [CNT_W-1:0] r_cnt;
  logic             w_miss;
  logic             w_take;
  stage_t           w_new;

  assign w_miss = in_valid & (load_in | WMEM_in) & ~mem_ready;
  assign w_take = in_valid & ~w_miss;

  always_comb begin
    w_new = '0;
    if (w_take) begin
      w_new.valid  = 1'b1;
      w_new.wb     = WB_in;
      w_new.wmem   = WMEM_in;
      w_new.load   = load_in;
      w_new.result = result_in;
      w_new.wdmem  = wdMem_in;
      w_new.rd     = rd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stg[i] <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) r_stg[i] <= '0;
    end else if (!stall) begin
      r_stg[0] <= w_new;
      for (int i = 1; i < STAGES; i++) r_stg[i] <= r_stg[i-1];
      if (!w_take && r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign WB_out     = r_stg[STAGES-1].wb;
  assign WMEM_out   = r_stg[STAGES-1].wmem;
  assign load_out   = r_stg[STAGES-1].load;
  assign result_out = r_stg[STAGES-1].result;
  assign wdMem_out  = r_stg[STAGES-1].wdmem;
  assign rd_out     = r_stg[STAGES-1].rd;
  assign out_valid  = r_stg[STAGES-1].valid;
  assign stall_req  = w_miss;
  assign bubble_cnt = r_cnt;

  logic [STAGES-1:0]        w_sel;
  logic [STAGES*RD_W-1:0]   w_rd;
  logic [STAGES*DATA_W-1:0] w_data;

  for (genvar g = 0; g < STAGES; g++) begin : g_flat
    assign w_sel[g] = r_stg[g].valid & r_stg[g].wb;
    assign w_rd[g*RD_W +: RD_W] = r_stg[g].rd;
    assign w_data[g*DATA_W +: DATA_W] = r_stg[g].result;
  end

  fwd_match #(
    .DATA_W(DATA_W), .RD_W(RD_W), .N(STAGES)
  ) u_fwd_rs (
    .i_sel (w_sel),
    .i_rd  (w_rd),
    .i_data(w_data),
    .i_src (src_rs),
    .o_hit (fwd_rs_hit),
    .o_data(fwd_rs_data)
  );

  fwd_match #(
    .DATA_W(DATA_W), .RD_W(RD_W), .N(STAGES)
  ) u_fwd_rt (
    .i_sel (w_sel),
    .i_rd  (w_rd),
    .i_data(w_data),
    .i_src (src_rt),
    .o_hit (fwd_rt_hit),
    .o_data(fwd_rt_data)
  );

endmodule

// File: tb/tb_memwb_stage_reg.sv
// Bench: three depths driven in parallel against a history model.
module tb_memwb_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, WB_in = 1'b0;
  logic        WMEM_in = 1'b0, load_in = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] result_in = '0, wdMem_in = '0;
  logic [4:0]  rd_in = '0, src_rs = '0, src_rt = '0;

  logic        wb_o [3], wm_o [3], ld_o [3], ov_o [3];
  logic        sr_o [3], rh_o [3], th_o [3];
  logic [31:0] res_o [3], wd_o [3], rdat_o [3], tdat_o [3];
  logic [4:0]  rd_o [3];
  logic [3:0]  cnt1;
  logic [15:0] cnt2, cnt3;

  memwb_stage_reg #(.STAGES(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .WB_in(WB_in), .WMEM_in(WMEM_in),
    .load_in(load_in), .result_in(result_in),
    .wdMem_in(wdMem_in), .rd_in(rd_in), .mem_ready(mem_ready),
    .WB_out(wb_o[0]), .WMEM_out(wm_o[0]), .load_out(ld_o[0]),
    .result_out(res_o[0]), .wdMem_out(wd_o[0]),
    .rd_out(rd_o[0]), .out_valid(ov_o[0]),
    .stall_req(sr_o[0]), .src_rs(src_rs), .src_rt(src_rt),
    .fwd_rs_hit(rh_o[0]), .fwd_rs_data(rdat_o[0]),
    .fwd_rt_hit(th_o[0]), .fwd_rt_data(tdat_o[0]),
    .bubble_cnt(cnt1)
  );

  memwb_stage_reg #(.STAGES(2)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .WB_in(WB_in), .WMEM_in(WMEM_in),
    .load_in(load_in), .result_in(result_in),
    .wdMem_in(wdMem_in), .rd_in(rd_in), .mem_ready(mem_ready),
    .WB_out(wb_o[1]), .WMEM_out(wm_o[1]), .load_out(ld_o[1]),
    .result_out(res_o[1]), .wdMem_out(wd_o[1]),
    .rd_out(rd_o[1]), .out_valid(ov_o[1]),
    .stall_req(sr_o[1]), .src_rs(src_rs), .src_rt(src_rt),
    .fwd_rs_hit(rh_o[1]), .fwd_rs_data(rdat_o[1]),
    .fwd_rt_hit(th_o[1]), .fwd_rt_data(tdat_o[1]),
    .bubble_cnt(cnt2)
  );

  memwb_stage_reg #(.STAGES(3)) u3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .WB_in(WB_in), .WMEM_in(WMEM_in),
    .load_in(load_in), .result_in(result_in),
    .wdMem_in(wdMem_in), .rd_in(rd_in), .mem_ready(mem_ready),
    .WB_out(wb_o[2]), .WMEM_out(wm_o[2]), .load_out(ld_o[2]),
    .result_out(res_o[2]), .wdMem_out(wd_o[2]),
    .rd_out(rd_o[2]), .out_valid(ov_o[2]),
    .stall_req(sr_o[2]), .src_rs(src_rs), .src_rt(src_rt),
    .fwd_rs_hit(rh_o[2]), .fwd_rs_data(rdat_o[2]),
    .fwd_rt_hit(th_o[2]), .fwd_rt_data(tdat_o[2]),
    .bubble_cnt(cnt3)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // h[0] is the most recent instruction slot seen by the pipe
  typedef struct packed {
    logic        v, wb, wm, ld;
    logic [31:0] res, wd;
    logic [4:0]  rd;
  } ent_t;

  ent_t        h [3];
  int unsigned nb = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    ent_t e;
    bit   miss;
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < 3; i++) h[i] = '0;
      nb = 0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) h[i] = '0;
    end else if (!stall) begin
      miss = (load_in || WMEM_in) && !mem_ready;
      e = '0;
      if (in_valid && !miss) begin
        e.v = 1'b1; e.wb = WB_in; e.wm = WMEM_in;
        e.ld = load_in; e.res = result_in;
        e.wd = wdMem_in; e.rd = rd_in;
      end else begin
        nb++;
      end
      h[2] = h[1]; h[1] = h[0]; h[0] = e;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        ent_t        o;
        logic        rh, th;
        logic [31:0] rdv, tdv;
        int unsigned lim, ec;
        logic [15:0] dc;
        o = h[k];
        rh = 1'b0; th = 1'b0; rdv = '0; tdv = '0;
        for (int i = k; i >= 0; i--) begin
          if (h[i].v && h[i].wb && src_rs != 0
              && h[i].rd == src_rs) begin
            rh = 1'b1; rdv = h[i].res;
          end
          if (h[i].v && h[i].wb && src_rt != 0
              && h[i].rd == src_rt) begin
            th = 1'b1; tdv = h[i].res;
          end
        end
        lim = (k == 0) ? 15 : 65535;
        ec  = (nb > lim) ? lim : nb;
        dc  = (k == 0) ? {12'd0, cnt1} : (k == 1) ? cnt2 : cnt3;
        chk($sformatf("u%0d.out_valid", k+1), 32'(ov_o[k]), 32'(o.v));
        chk($sformatf("u%0d.WB_out", k+1), 32'(wb_o[k]), 32'(o.wb));
        chk($sformatf("u%0d.WMEM_out", k+1), 32'(wm_o[k]), 32'(o.wm));
        chk($sformatf("u%0d.load_out", k+1), 32'(ld_o[k]), 32'(o.ld));
        chk($sformatf("u%0d.result_out", k+1), res_o[k], o.res);
        chk($sformatf("u%0d.wdMem_out", k+1), wd_o[k], o.wd);
        chk($sformatf("u%0d.rd_out", k+1), 32'(rd_o[k]), 32'(o.rd));
        chk($sformatf("u%0d.stall_req", k+1), 32'(sr_o[k]),
            32'(in_valid && (load_in || WMEM_in) && !mem_ready));
        chk($sformatf("u%0d.fwd_rs_hit", k+1), 32'(rh_o[k]), 32'(rh));
        chk($sformatf("u%0d.fwd_rs_data", k+1), rdat_o[k], rdv);
        chk($sformatf("u%0d.fwd_rt_hit", k+1), 32'(th_o[k]), 32'(th));
        chk($sformatf("u%0d.fwd_rt_data", k+1), tdat_o[k], tdv);
        chk($sformatf("u%0d.bubble_cnt", k+1), 32'(dc), ec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic wb,
                     input logic [4:0] rd, input logic [31:0] res);
    in_valid = v; WB_in = wb; rd_in = rd; result_in = res;
  endtask

  initial begin
    // reset with live inputs
    put(1, 1, 5'd3, 32'hFF);
    tick(); tick();
    @(negedge clk);
    chk("rst.u1.out_valid", 32'(ov_o[0]), 32'd0);
    chk("rst.u1.result", res_o[0], 32'd0);
    chk("rst.u1.cnt", 32'(cnt1), 32'd0);
    chk("rst.u3.WB_out", 32'(wb_o[2]), 32'd0);
    rst = 1'b0;
    put(1, 1, 5'd5, 32'h1234);
    tick();
    put(0, 0, 5'd0, 32'h0);
    @(negedge clk);
    chk("pass.u1.valid", 32'(ov_o[0]), 32'd1);
    chk("pass.u2.early", 32'(ov_o[1]), 32'd0);
    tick();
    @(negedge clk);
    chk("pass.u2.valid", 32'(ov_o[1]), 32'd1);
    chk("pass.u2.rd", 32'(rd_o[1]), 32'd5);
    chk("pass.u2.result", res_o[1], 32'h1234);

    // cache miss
    rst = 1'b1;
    tick();
    rst = 1'b0;
    put(1, 1, 5'd9, 32'h55);
    load_in = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("miss.stall_req", 32'(sr_o[0]), 32'd1);
    tick(); tick(); tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("miss.cnt3", 32'(cnt1), 32'd3);
    chk("miss.bubble_out", 32'(ov_o[0]), 32'd0);
    chk("miss.req_drop", 32'(sr_o[0]), 32'd0);
    tick();
    put(0, 0, 5'd0, 32'h0);
    load_in = 1'b0;
    @(negedge clk);
    chk("miss.load_out", 32'(ld_o[0]), 32'd1);
    chk("miss.rd", 32'(rd_o[0]), 32'd9);
    chk("miss.cnt_hold", 32'(cnt1), 32'd3);

    // stall then stall+flush
    rst = 1'b1;
    tick();
    rst = 1'b0;
    put(1, 1, 5'd10, 32'hAA); tick();
    put(1, 1, 5'd11, 32'hBB); tick();
    put(1, 1, 5'd12, 32'hCC); tick();
    put(1, 1, 5'd13, 32'hDD);
    stall = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("stall.u3.rd", 32'(rd_o[2]), 32'd10);
    chk("stall.u3.result", res_o[2], 32'hAA);
    chk("stall.u1.rd", 32'(rd_o[0]), 32'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    put(0, 0, 5'd0, 32'h0);
    @(negedge clk);
    chk("flush.u3.valid", 32'(ov_o[2]), 32'd0);
    chk("flush.u3.WB", 32'(wb_o[2]), 32'd0);
    chk("flush.u1.cnt", 32'(cnt1), 32'd0);

    // forwarding priority
    put(1, 1, 5'd7, 32'hB); tick();
    put(1, 1, 5'd0, 32'h99); tick();
    put(1, 1, 5'd7, 32'hA); tick();
    src_rs = 5'd7; src_rt = 5'd0;
    @(negedge clk);
    chk("fwd.u3.rs_hit", 32'(rh_o[2]), 32'd1);
    chk("fwd.u3.rs_data", rdat_o[2], 32'hA);
    chk("fwd.u3.rt_hit", 32'(th_o[2]), 32'd0);
    chk("fwd.u3.rt_data", tdat_o[2], 32'd0);
    chk("fwd.u3.result", res_o[2], 32'hB);
    put(1, 0, 5'd7, 32'hC);
    WMEM_in = 1'b1; wdMem_in = 32'h77;
    tick();
    put(0, 0, 5'd0, 32'h0);
    WMEM_in = 1'b0;
    @(negedge clk);
    chk("store.u3.rs_data", rdat_o[2], 32'hA);
    chk("store.u1.rs_hit", 32'(rh_o[0]), 32'd0);
    chk("store.u1.WMEM", 32'(wm_o[0]), 32'd1);
    chk("store.u1.wdMem", wd_o[0], 32'h77);

    // saturation
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("sat.u1.cnt", 32'(cnt1), 32'd15);
    chk("sat.u2.cnt", 32'(cnt2), 32'd20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/memwb_stage_reg.md
Name: memwb_stage_reg

Overview:
- Parametrised MEM/WB pipeline register for the MIPS pipeline; sits between the data-cache/MEM stage and register-file writeback.
- Generalises the fixed single-stage MEM/WB latch:
  - configurable data/register widths and depth (1-3 stages, to absorb deeper cache latency);
  - stall, flush and cache-miss bubble insertion;
  - per-stage valid tracking;
  - built-in forwarding lookup and a bubble counter.

Parameters:
DATA_W, 32, width of result and store-data fields
RD_W, 5, destination register index width
STAGES, 1, number of register stages (legal 1..3; other values illegal)
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold all stages
flush  in  1  squash all stages
in_valid  in  1  input slot carries a real instruction
WB_in  in  1  register writeback enable
WMEM_in  in  1  memory write
load_in  in  1  memory read
result_in  in  DATA_W  writeback value
wdMem_in  in  DATA_W  store data
rd_in  in  RD_W  destination register
mem_ready  in  1  cache has completed the access for the current input
WB_out  out  1  writeback enable, last stage
WMEM_out  out  1  memory write, last stage
load_out  out  1  load flag, last stage
result_out  out  DATA_W  writeback value, last stage
wdMem_out  out  DATA_W  store data, last stage
rd_out  out  RD_W  destination, last stage
out_valid  out  1  last stage holds a real instruction
stall_req  out  1  upstream must hold (cache miss)
src_rs  in  RD_W  forwarding query A
src_rt  in  RD_W  forwarding query B
fwd_rs_hit  out  1  query A matches an in-flight writer
fwd_rs_data  out  DATA_W  forwarded value A
fwd_rt_hit  out  1  query B matches an in-flight writer
fwd_rt_data  out  DATA_W  forwarded value B
bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Stages: stage 0 captures the inputs; stage i captures stage i-1; outputs are driven from stage STAGES-1.
  - Latency is STAGES cycles; throughput is 1 per cycle.
- Reset: every stage field is 0, so all outputs are 0, out_valid=0 and bubble_cnt=0.
- Per-edge priority: rst > flush > stall > advance.
- flush: every stage gets valid=0 with all control and data fields 0. Flush overrides a concurrent stall. Flush cycles do not count as bubbles.
- stall (no flush): all stages and bubble_cnt hold.
- miss = in_valid & (load_in | WMEM_in) & ~mem_ready.
  - stall_req = miss. It is combinational and independent of stall/flush.
- Advance (no rst/flush/stall):
  - Stages 1.. shift normally.
  - Stage 0 takes a bubble if ~in_valid or miss; otherwise it takes the input with valid=1.
- Bubble definition: valid=0; WB, WMEM, load = 0; data fields 0.
- Control masking: stored controls are masked by valid on capture, so WB_out/WMEM_out/load_out are never 1 when out_valid=0.
- bubble_cnt: +1 on each advance edge where stage 0 takes a bubble; saturates at all-ones (no wrap).
- Forwarding (combinational):
  - A stage matches a query when valid & WB & rd == src & src != 0.
  - The youngest stage (lowest index) wins.
  - hit=0 gives data=0.
  - Queries against register 0 never hit.
- A store (WMEM=1, WB=0) never forwards.

Decomposition:
- Shared package `pipe_pkg`:
  - typedef for the MEM/WB payload struct (WB, WMEM, load, result, wdMem, rd, valid);
  - BUBBLE constant;
  - default DATA_W/RD_W.
- One natural sub-module, `fwd_match`: priority search over the stage array, instantiated once per query port.

Test Plan:
- Reset, STAGES=1: rst=1 for 2 cycles with inputs nonzero -> all outputs 0, bubble_cnt=0.
- Basic pass, STAGES=2: in_valid=1, WB_in=1, rd_in=5, result_in=0x1234 -> out_valid=1, rd_out=5, result_out=0x1234 exactly 2 cycles later.
- Cache miss: load_in=1, in_valid=1, mem_ready=0 for 3 cycles then 1:
  - stall_req=1 for 3 cycles;
  - 3 bubbles emitted, bubble_cnt=3;
  - the load then emerges with load_out=1.
- Stall vs flush: pipe full, stall=1 for 2 cycles -> outputs frozen; then stall=1 and flush=1 together -> next cycle out_valid=0, WB_out=0, bubble_cnt unchanged.
- Forwarding, STAGES=3:
  - stage0 rd=7 result=0xA, stage2 rd=7 result=0xB, src_rs=7 -> fwd_rs_hit=1, data=0xA;
  - src_rt=0 with a rd=0 writer present -> fwd_rt_hit=0;
  - store to rd=7 in stage0 -> the store is not selected.
- Counter saturation, CNT_W=4: 20 consecutive advance cycles with in_valid=0 -> bubble_cnt stops at 15.
